// File: rtl/soc_bus_pkg.sv
// Shared SoC bus definitions: bus widths, FSM state encoding for the
// Wishbone slave mux, the SoC memory map (also used by the CLINT for its
// address parameters), and the latched request payload.
package soc_bus_pkg;

    localparam int unsigned ADR_W    = 32;
    localparam int unsigned DAT_W    = 32;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned SOC_NSLV = 4;

    // Mux FSM state encoding
    typedef logic [1:0] bus_state_t;
    localparam bus_state_t ST_IDLE = 2'd0;
    localparam bus_state_t ST_BUSY = 2'd1;
    localparam bus_state_t ST_RESP = 2'd2;

    // SoC memory map
    localparam logic [ADR_W-1:0] RAM_BASE   = 32'h0000_0000;
    localparam logic [ADR_W-1:0] RAM_MASK   = 32'hF000_0000;
    localparam logic [ADR_W-1:0] UART_BASE  = 32'h2000_0000;
    localparam logic [ADR_W-1:0] UART_MASK  = 32'hFFFF_FF00;
    localparam logic [ADR_W-1:0] CLINT_BASE = 32'h2000_0C00;
    localparam logic [ADR_W-1:0] CLINT_MASK = 32'hFFFF_FFF0;
    localparam logic [ADR_W-1:0] GPIO_BASE  = 32'h2000_0100;
    localparam logic [ADR_W-1:0] GPIO_MASK  = 32'hFFFF_FF00;

    // Flattened per-slave tables, slave i at bits [32i+31:32i]
    localparam logic [SOC_NSLV*ADR_W-1:0] SOC_SLV_BASE =
        {GPIO_BASE, CLINT_BASE, UART_BASE, RAM_BASE};
    localparam logic [SOC_NSLV*ADR_W-1:0] SOC_SLV_MASK =
        {GPIO_MASK, CLINT_MASK, UART_MASK, RAM_MASK};

    // Master request as latched by the mux and replayed to the slave
    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_slave_mux_if.sv
// Wishbone classic bundle seen by the slave mux: the master-side port
// (m_*) and the fan-out to NSLV slaves (s_*).
//   slave modport  : view of the mux itself
//   master modport : view of the surrounding core/peripherals
interface wb_slave_mux_if
    import soc_bus_pkg::*;
#(
    parameter int unsigned NSLV = 4
);
    logic                    m_cyc_i;
    logic                    m_stb_i;
    logic [ADR_W-1:0]        m_adr_i;
    logic                    m_we_i;
    logic [SEL_W-1:0]        m_sel_i;
    logic [DAT_W-1:0]        m_dat_i;
    logic [DAT_W-1:0]        m_dat_o;
    logic                    m_ack_o;
    logic                    m_err_o;

    logic [NSLV-1:0]         s_cyc_o;
    logic [NSLV-1:0]         s_stb_o;
    logic [ADR_W-1:0]        s_adr_o;
    logic                    s_we_o;
    logic [SEL_W-1:0]        s_sel_o;
    logic [DAT_W-1:0]        s_dat_o;
    logic [NSLV*DAT_W-1:0]   s_dat_i;
    logic [NSLV-1:0]         s_ack_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_adr_i, m_we_i, m_sel_i, m_dat_i,
        output m_dat_o, m_ack_o, m_err_o,
        output s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_sel_o, s_dat_o,
        input  s_dat_i, s_ack_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_adr_i, m_we_i, m_sel_i, m_dat_i,
        input  m_dat_o, m_ack_o, m_err_o,
        input  s_cyc_o, s_stb_o, s_adr_o, s_we_o, s_sel_o, s_dat_o,
        output s_dat_i, s_ack_i
    );

endinterface

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: slave i matches when
// (adr & mask_i) == base_i; the lowest matching index wins.
//   adr        : address to decode
//   match_oh_c : one-hot winning slave (all zero when unmapped)
//   hit_c      : at least one slave matched
module wb_addr_decode
    import soc_bus_pkg::*;
#(
    parameter int unsigned              NSLV     = 4,
    parameter logic [NSLV*ADR_W-1:0]    SLV_BASE = (NSLV*ADR_W)'(SOC_SLV_BASE),
    parameter logic [NSLV*ADR_W-1:0]    SLV_MASK = (NSLV*ADR_W)'(SOC_SLV_MASK)
) (
    input  logic [ADR_W-1:0] adr,
    output logic [NSLV-1:0]  match_oh_c,
    output logic             hit_c
);

    logic [NSLV-1:0] raw_c;

    // Raw per-slave base/mask compare
    always_comb begin
        raw_c = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            raw_c[i] = ((adr & SLV_MASK[i*ADR_W +: ADR_W]) == SLV_BASE[i*ADR_W +: ADR_W]);
        end
    end

    // Isolate the lowest set bit for fixed priority
    assign match_oh_c = raw_c & (~raw_c + NSLV'(1));
    assign hit_c      = |raw_c;

endmodule

// File: rtl/wb_slave_mux.sv
// Single-master to NSLV-slave Wishbone classic mux. Latches one master
// request, forwards it to the decoded slave, and returns a single-cycle
// ack (with read data) or error (unmapped address / slave timeout).
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : master port m_* and slave fan-out s_* (slave modport)
module wb_slave_mux
    import soc_bus_pkg::*;
#(
    parameter int unsigned              NSLV           = 4,
    parameter logic [NSLV*ADR_W-1:0]    SLV_BASE       = (NSLV*ADR_W)'(SOC_SLV_BASE),
    parameter logic [NSLV*ADR_W-1:0]    SLV_MASK       = (NSLV*ADR_W)'(SOC_SLV_MASK),
    parameter int unsigned              TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    wb_slave_mux_if.slave   bus
);

    localparam int unsigned      CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    bus_state_t       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    wb_req_t          req_q,    req_d;
    logic [NSLV-1:0]  oh_q,     oh_d;
    logic [NSLV-1:0]  s_cyc_q,  s_cyc_d;
    logic [NSLV-1:0]  s_stb_q,  s_stb_d;
    logic [DAT_W-1:0] rdat_q,   rdat_d;
    logic             ack_q,    ack_d;
    logic             err_q,    err_d;

    logic [NSLV-1:0]  dec_oh_c;
    logic             dec_hit_c;
    logic             ack_hit_c;
    logic [DAT_W-1:0] slv_rdat_c;

    wb_addr_decode #(
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_decode (
        .adr        (bus.m_adr_i),
        .match_oh_c (dec_oh_c),
        .hit_c      (dec_hit_c)
    );

    // Only the latched slave's ack counts; everyone else is ignored
    assign ack_hit_c = |(bus.s_ack_i & oh_q);

    // Read data of the latched slave (one-hot select)
    always_comb begin
        slv_rdat_c = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            if (oh_q[i]) begin
                slv_rdat_c = slv_rdat_c | bus.s_dat_i[i*DAT_W +: DAT_W];
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        oh_d    = oh_q;
        s_cyc_d = '0;
        s_stb_d = '0;
        rdat_d  = '0;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.m_cyc_i && bus.m_stb_i) begin
                    req_d.adr = bus.m_adr_i;
                    req_d.we  = bus.m_we_i;
                    req_d.sel = bus.m_sel_i;
                    req_d.dat = bus.m_dat_i;
                    oh_d      = dec_oh_c;
                    if (dec_hit_c) begin
                        state_d = ST_BUSY;
                        cnt_d   = '0;
                        s_cyc_d = dec_oh_c;
                        s_stb_d = dec_oh_c;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end
                end
            end

            ST_BUSY: begin
                // Abort beats ack, ack beats timeout
                if (!bus.m_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (ack_hit_c) begin
                    state_d = ST_RESP;
                    ack_d   = 1'b1;
                    rdat_d  = slv_rdat_c;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    s_cyc_d = oh_q;
                    s_stb_d = oh_q;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            req_q   <= '0;
            oh_q    <= '0;
            s_cyc_q <= '0;
            s_stb_q <= '0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            oh_q    <= oh_d;
            s_cyc_q <= s_cyc_d;
            s_stb_q <= s_stb_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign bus.m_dat_o = rdat_q;
    assign bus.m_ack_o = ack_q;
    assign bus.m_err_o = err_q;
    assign bus.s_cyc_o = s_cyc_q;
    assign bus.s_stb_o = s_stb_q;
    assign bus.s_adr_o = req_q.adr;
    assign bus.s_we_o  = req_q.we;
    assign bus.s_sel_o = req_q.sel;
    assign bus.s_dat_o = req_q.dat;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Bench for wb_slave_mux: directed cases from the memory map plus random
// transactions against a transaction-level expectation model.
module tb_wb_slave_mux;

    localparam int unsigned NS = 4;
    localparam int          T  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_slave_mux_if #(.NSLV(NS)) bus_if ();

    wb_slave_mux #(
        .NSLV           (NS),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    // Memory map as documented for the SoC
    logic [31:0] map_base [NS] = '{32'h0000_0000, 32'h2000_0000, 32'h2000_0c00, 32'h2000_0100};
    logic [31:0] map_mask [NS] = '{32'hF000_0000, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hFFFF_FF00};

    // Slave models: ack after lat cycles of strobe (0 = same cycle)
    int          lat   [NS];
    logic [31:0] rdata [NS];
    int          stb_age [NS];
    logic [NS-1:0] noise = '0;
    logic [NS-1:0] ack_vec;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            stb_age[i] <= bus_if.s_stb_o[i] ? stb_age[i] + 1 : 0;
        end
    end

    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NS; i++) begin
            ack_vec[i] = (bus_if.s_stb_o[i] && (stb_age[i] >= lat[i])) || noise[i];
        end
    end

    assign bus_if.s_ack_i = ack_vec;
    assign bus_if.s_dat_i = {rdata[3], rdata[2], rdata[1], rdata[0]};

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int model_decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & map_mask[i]) == map_base[i]) return i;
        end
        return -1;
    endfunction

    task automatic master_idle();
        bus_if.m_cyc_i = 1'b0;
        bus_if.m_stb_i = 1'b0;
    endtask

    // One master transaction; abort_at > 0 drops cyc after that many strobe cycles
    task automatic run_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat, input int abort_at);
        int          idx;
        int          exp_stb, exp_ack, exp_err, exp_rc;
        logic [31:0] exp_dat;
        logic [NS-1:0] exp_oh;
        logic [NS-1:0] nmask;
        int          k, stb_cnt, n_ack, n_err, rc, tail;
        logic [31:0] got_dat;
        bit          bad_pat, bad_fields, bad_dat0, dropped, done;

        idx = model_decode(adr);
        exp_oh = '0;
        nmask  = '1;
        if (idx >= 0) begin
            exp_oh[idx] = 1'b1;
            nmask = ~exp_oh;
        end
        exp_ack = 0; exp_err = 0; exp_rc = -1; exp_dat = '0;
        if (idx < 0) begin
            exp_stb = 0; exp_err = 1; exp_rc = 1;
        end else if (abort_at > 0) begin
            exp_stb = abort_at;
        end else if (lat[idx] < T) begin
            exp_stb = lat[idx] + 1; exp_ack = 1; exp_rc = exp_stb + 1; exp_dat = rdata[idx];
        end else begin
            exp_stb = T; exp_err = 1; exp_rc = T + 1;
        end

        @(negedge clk);
        bus_if.m_cyc_i = 1'b1;
        bus_if.m_stb_i = 1'b1;
        bus_if.m_adr_i = adr;
        bus_if.m_we_i  = we;
        bus_if.m_sel_i = sel;
        bus_if.m_dat_i = wdat;
        noise = NS'($urandom) & nmask;

        k = 0; stb_cnt = 0; n_ack = 0; n_err = 0; rc = -1; tail = 0; got_dat = '0;
        bad_pat = 0; bad_fields = 0; bad_dat0 = 0; dropped = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            k++;
            if (bus_if.s_stb_o != '0) begin
                stb_cnt++;
                if (bus_if.s_stb_o != exp_oh) bad_pat = 1;
                if (bus_if.s_cyc_o != bus_if.s_stb_o || bus_if.s_adr_o != adr ||
                    bus_if.s_we_o != we || bus_if.s_sel_o != sel || bus_if.s_dat_o != wdat)
                    bad_fields = 1;
            end else if (bus_if.s_cyc_o != '0) begin
                bad_pat = 1;
            end
            if (bus_if.m_ack_o || bus_if.m_err_o) begin
                if (bus_if.m_ack_o) n_ack++;
                if (bus_if.m_err_o) n_err++;
                if (rc < 0) begin
                    rc = k;
                    got_dat = bus_if.m_dat_o;
                    master_idle();
                    tail = 3;
                end
            end else if (bus_if.m_dat_o != '0) begin
                bad_dat0 = 1;
            end
            if (abort_at > 0 && !dropped && stb_cnt == abort_at) begin
                dropped = 1;
                master_idle();
                tail = 4;
            end
            noise = NS'($urandom) & nmask;
            if (tail > 0) begin
                tail--;
                if (tail == 0) done = 1;
            end
            if (k >= T + 12) done = 1;
        end
        master_idle();
        noise = '0;

        check_eq("stb_cycles", 32'(stb_cnt), 32'(exp_stb));
        check_eq("stb_onehot", 32'(bad_pat), 32'd0);
        check_eq("slave_fields", 32'(bad_fields), 32'd0);
        check_eq("ack_count", 32'(n_ack), 32'(exp_ack));
        check_eq("err_count", 32'(n_err), 32'(exp_err));
        check_eq("dat_zero_outside_resp", 32'(bad_dat0), 32'd0);
        if (exp_rc > 0) begin
            check_eq("resp_cycle", 32'(rc), 32'(exp_rc));
            check_eq("resp_data", got_dat, exp_dat);
        end
    endtask

    // Idle gap with stray acks that must not produce a response
    task automatic idle_gap(input int n);
        bit seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus_if.m_ack_o || bus_if.m_err_o || bus_if.s_stb_o != '0) seen = 1;
            noise = NS'($urandom);
        end
        noise = '0;
        check_eq("idle_quiet", 32'(seen), 32'd0);
    endtask

    task automatic randomize_slaves();
        int pick;
        for (int i = 0; i < NS; i++) begin
            pick = int'($urandom_range(0, 7));
            case (pick)
                0, 1:    lat[i] = 0;
                2:       lat[i] = 1;
                3:       lat[i] = 2;
                4:       lat[i] = 3;
                5:       lat[i] = T - 1;
                6:       lat[i] = T;
                default: lat[i] = 100;
            endcase
            rdata[i] = $urandom;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        case ($urandom_range(0, 5))
            0:       a = {4'h0, 28'($urandom)};
            1:       a = 32'h2000_0000 | 32'($urandom_range(0, 255));
            2:       a = 32'h2000_0c00 | 32'($urandom_range(0, 15));
            3:       a = 32'h2000_0100 | 32'($urandom_range(0, 255));
            4:       a = 32'h3000_0000 | 32'($urandom_range(0, 255));
            default: a = $urandom;
        endcase
        return a;
    endfunction

    initial begin
        logic [31:0] a;
        int          ab;
        bit          late;

        master_idle();
        bus_if.m_adr_i = '0;
        bus_if.m_we_i  = 1'b0;
        bus_if.m_sel_i = '0;
        bus_if.m_dat_i = '0;
        for (int i = 0; i < NS; i++) begin
            lat[i]   = 0;
            rdata[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ack", 32'(bus_if.m_ack_o), 32'd0);
        check_eq("rst_err", 32'(bus_if.m_err_o), 32'd0);
        check_eq("rst_stb", 32'(bus_if.s_stb_o), 32'd0);
        check_eq("rst_adr", bus_if.s_adr_o, 32'd0);
        check_eq("rst_dat", bus_if.m_dat_o, 32'd0);
        rst = 1'b0;
        idle_gap(2);

        // CLINT read, combinational ack
        rdata[2] = 32'h0000_1234; lat[2] = 0;
        run_txn(32'h2000_0c08, 1'b0, 4'hf, 32'h0, 0);
        // RAM write
        rdata[0] = 32'h5555_aaaa; lat[0] = 1;
        run_txn(32'h0000_0040, 1'b1, 4'b0011, 32'hDEAD_BEEF, 0);
        // Unmapped
        run_txn(32'h3000_0000, 1'b0, 4'hf, 32'h0, 0);
        // UART never acks: timeout
        lat[1] = 100;
        run_txn(32'h2000_0010, 1'b0, 4'hf, 32'h0, 0);
        lat[1] = 0; rdata[1] = 32'h0000_00a5;
        run_txn(32'h2000_0004, 1'b0, 4'hf, 32'h0, 0);
        // Ack exactly on the last allowed cycle
        lat[2] = T - 1; rdata[2] = 32'hcafe_f00d;
        run_txn(32'h2000_0c04, 1'b0, 4'hf, 32'h0, 0);
        // GPIO stalled, master abort after two strobe cycles
        lat[3] = 100;
        run_txn(32'h2000_0100, 1'b1, 4'hf, 32'h1111_2222, 2);
        lat[3] = 0; rdata[3] = 32'h0000_0f0f;
        run_txn(32'h2000_0104, 1'b0, 4'hf, 32'h0, 0);

        // Reset while BUSY, then a late ack
        lat[3] = 100;
        @(negedge clk);
        bus_if.m_cyc_i = 1'b1; bus_if.m_stb_i = 1'b1;
        bus_if.m_adr_i = 32'h2000_0108; bus_if.m_we_i = 1'b1;
        bus_if.m_sel_i = 4'hf; bus_if.m_dat_i = 32'h7777_8888;
        repeat (2) @(negedge clk);
        check_eq("busy_stb", 32'(bus_if.s_stb_o), 32'h8);
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_stb", 32'(bus_if.s_stb_o), 32'd0);
        check_eq("midrst_cyc", 32'(bus_if.s_cyc_o), 32'd0);
        check_eq("midrst_ack", 32'(bus_if.m_ack_o), 32'd0);
        check_eq("midrst_adr", bus_if.s_adr_o, 32'd0);
        master_idle();
        rst = 1'b0;
        noise = 4'b1000;
        late = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus_if.m_ack_o || bus_if.m_err_o) late = 1;
        end
        noise = '0;
        check_eq("late_ack_ignored", 32'(late), 32'd0);
        lat[3] = 2; rdata[3] = 32'h0bad_cafe;
        run_txn(32'h2000_01fc, 1'b0, 4'hf, 32'h0, 0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            randomize_slaves();
            a  = rand_addr();
            ab = 0;
            if (model_decode(a) >= 0 && $urandom_range(0, 5) == 0) begin
                ab = int'($urandom_range(1, 3));
                lat[model_decode(a)] = 100;
            end
            run_txn(a, 1'($urandom), 4'($urandom), $urandom, ab);
            idle_gap(int'($urandom_range(1, 2)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
